// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// -----------------
// Multi-cycle unsigned multiplier that borrows the shared datapath ALU to do
// every add and shift of a shift-and-add multiply. It has no adder or shifter
// of its own. It produces the low WIDTH bits of a_in*b_in, modulo 2^WIDTH.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   start      request; only looked at while idle
//   a_in/b_in  multiplicand / multiplier, latched when start is accepted
//   busy       high while the ALU is owned (ADD/SHL/SHR)
//   done       one-cycle pulse; product is valid from here until next start
//   product    result register
//   alu_A/B/FS/C0  ALU operand outputs (zero when not busy)
//   alu_F      ALU result, combinational in the same cycle
//   alu_status ALU flags, not used
//   dbg_state  current FSM state, for observation only
//
// Handshake: start is a level sampled at the clock edge while idle. Requests
// that arrive while busy or during the done cycle are dropped, not queued.
module alu_mul_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_FS,
  output logic             alu_C0,
  input  logic [WIDTH-1:0] alu_F,
  input  logic [3:0]       alu_status,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SHL = 5'b10000;
  localparam logic [4:0] FS_SHR = 5'b10100;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] product_q;
  logic             busy_q;
  logic             done_q;

  // Flags carry no information for an unsigned low-half multiply.
  logic unused_status;
  assign unused_status = ^alu_status;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q    <= '0;
            mcand_q  <= a_in;
            mplier_q <= b_in;
            cnt_q    <= '0;
            if (b_in == '0) begin
              // Nothing to add: skip straight to DONE with a zero product.
              state_q   <= S_DONE;
              product_q <= '0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              state_q <= b_in[0] ? S_ADD : S_SHL;
              busy_q  <= 1'b1;
            end
          end
        end
        S_ADD: begin
          acc_q   <= alu_F;
          state_q <= S_SHL;
        end
        S_SHL: begin
          mcand_q <= alu_F;
          state_q <= S_SHR;
        end
        S_SHR: begin
          mplier_q <= alu_F;
          cnt_q    <= cnt_q + CNT_W'(1);
          // alu_F is the shifted multiplier: once it is zero no set bits
          // remain, so stop early instead of walking all WIDTH bits.
          if (alu_F == '0 || cnt_q == LAST_CNT) begin
            state_q   <= S_DONE;
            product_q <= acc_q;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            state_q <= alu_F[0] ? S_ADD : S_SHL;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The ALU answers in the same cycle, so its operands are decoded directly
  // from the current state and registers rather than pipelined.
  always_comb begin
    alu_A  = '0;
    alu_B  = '0;
    alu_FS = '0;
    alu_C0 = 1'b0;
    case (state_q)
      S_ADD: begin
        alu_A  = acc_q;
        alu_B  = mcand_q;
        alu_FS = FS_ADD;
      end
      S_SHL: begin
        alu_A  = mcand_q;
        alu_B  = WIDTH'(1);
        alu_FS = FS_SHL;
      end
      S_SHR: begin
        alu_A  = mplier_q;
        alu_B  = WIDTH'(1);
        alu_FS = FS_SHR;
      end
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer. Contains a behavioural ALU model and a
// reference multiply model (product, latency, ALU function sequence).
module tb_alu_mul_sequencer;
  localparam int W = 64;

  // clock/reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         busy, done;
  logic [W-1:0] product;
  logic [W-1:0] alu_A, alu_B, alu_F;
  logic [4:0]   alu_FS;
  logic         alu_C0;
  logic [3:0]   alu_status;
  logic [2:0]   dbg_state;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .clock(clock), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product),
    .alu_A(alu_A), .alu_B(alu_B), .alu_FS(alu_FS), .alu_C0(alu_C0),
    .alu_F(alu_F), .alu_status(alu_status), .dbg_state(dbg_state)
  );

  // Shared ALU: add, shift left, shift right
  always_comb begin
    case (alu_FS)
      5'b01000: alu_F = alu_A + alu_B + {{(W-1){1'b0}}, alu_C0};
      5'b10000: alu_F = alu_A << alu_B[5:0];
      5'b10100: alu_F = alu_A >> alu_B[5:0];
      default:  alu_F = '0;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: expected / observed ALU function sequences
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  int         done_cycle;
  int         busy_cycles;
  int         c0_high;
  logic [W-1:0] prod_seen;

  // reference model
  function automatic logic [W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
    return a * b;
  endfunction

  function automatic int model_latency(input logic [W-1:0] b);
    int lat;
    int hb;
    lat = 1;
    hb  = -1;
    for (int i = 0; i < W; i++) if (b[i]) hb = i;
    for (int i = 0; i <= hb; i++) lat += b[i] ? 3 : 2;
    return lat;
  endfunction

  function automatic void model_fs(input logic [W-1:0] b);
    int hb;
    exp_q.delete();
    hb = -1;
    for (int i = 0; i < W; i++) if (b[i]) hb = i;
    for (int i = 0; i <= hb; i++) begin
      if (b[i]) exp_q.push_back(5'b01000);
      exp_q.push_back(5'b10000);
      exp_q.push_back(5'b10100);
    end
  endfunction

  function automatic int fs_diff();
    int d;
    d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                      : exp_q.size() - obs_q.size();
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  // driver tasks
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Observe cycles 1..budget after the start edge, at negedges.
  task automatic collect(input int budget);
    obs_q.delete();
    done_cycle  = -1;
    busy_cycles = 0;
    c0_high     = 0;
    prod_seen   = 'x;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      if (busy) begin
        busy_cycles++;
        obs_q.push_back(alu_FS);
        if (alu_C0) c0_high++;
      end
      if (done) begin
        done_cycle = k;
        prod_seen  = product;
        break;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (product !== '0) begin n_fail++; $display("FAIL reset_product got %h want 0", product); end
    n_checks++;
    if ({alu_A, alu_B, alu_FS, alu_C0} !== '0) begin
      n_fail++; $display("FAIL reset_alu got A=%h B=%h FS=%b C0=%b want all 0", alu_A, alu_B, alu_FS, alu_C0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_FS !== 5'b0) begin
      n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b FS=%b want 0 0 0", busy, done, alu_FS);
    end
  endtask

  task automatic test_basic();
    start_op(64'd6, 64'd3);
    collect(50);
    model_fs(64'd3);
    n_checks++; if (done_cycle != 7) begin n_fail++; $display("FAIL basic_latency got %0d want 7", done_cycle); end
    n_checks++; if (prod_seen !== 64'd18) begin n_fail++; $display("FAIL basic_product got %0d want 18", prod_seen); end
    n_checks++; if (busy_cycles != 6) begin n_fail++; $display("FAIL basic_busy got %0d want 6", busy_cycles); end
    n_checks++; if (fs_diff() != 0) begin n_fail++; $display("FAIL basic_fs_seq got %0d diffs want 0", fs_diff()); end
    n_checks++; if (c0_high != 0) begin n_fail++; $display("FAIL basic_c0 got %0d cycles high want 0", c0_high); end
    @(negedge clock);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
    repeat (3) @(negedge clock);
    n_checks++; if (product !== 64'd18) begin n_fail++; $display("FAIL basic_product_hold got %0d want 18", product); end
  endtask

  task automatic test_zero();
    start_op(64'd5, 64'd0);
    collect(10);
    n_checks++; if (done_cycle != 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", done_cycle); end
    n_checks++; if (prod_seen !== 64'd0) begin n_fail++; $display("FAIL zero_product got %0d want 0", prod_seen); end
    n_checks++; if (busy_cycles != 0) begin n_fail++; $display("FAIL zero_busy got %0d want 0", busy_cycles); end
  endtask

  task automatic test_wrap();
    start_op(64'h8000000000000000, 64'd2);
    collect(50);
    model_fs(64'd2);
    n_checks++; if (done_cycle != 6) begin n_fail++; $display("FAIL wrap_latency got %0d want 6", done_cycle); end
    n_checks++; if (prod_seen !== 64'd0) begin n_fail++; $display("FAIL wrap_product got %h want 0", prod_seen); end
    n_checks++; if (fs_diff() != 0) begin n_fail++; $display("FAIL wrap_fs_seq got %0d diffs want 0", fs_diff()); end
  endtask

  task automatic test_all_ones();
    start_op(64'd1, '1);
    collect(300);
    model_fs('1);
    n_checks++; if (done_cycle != 193) begin n_fail++; $display("FAIL ones_latency got %0d want 193", done_cycle); end
    n_checks++; if (prod_seen !== '1) begin n_fail++; $display("FAIL ones_product got %h want all ones", prod_seen); end
    n_checks++; if (busy_cycles != 192) begin n_fail++; $display("FAIL ones_busy got %0d want 192", busy_cycles); end
    n_checks++; if (fs_diff() != 0) begin n_fail++; $display("FAIL ones_fs_seq got %0d diffs want 0", fs_diff()); end
  endtask

  task automatic test_ignore_start();
    int idle_busy;
    start_op(64'd7, 64'd9);
    done_cycle = -1;
    prod_seen  = 'x;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (k == 3) begin start = 1'b1; a_in = 64'd2; b_in = 64'd2; end
      else start = 1'b0;
      if (done) begin done_cycle = k; prod_seen = product; break; end
    end
    n_checks++; if (done_cycle != 11) begin n_fail++; $display("FAIL ignore_latency got %0d want 11", done_cycle); end
    n_checks++; if (prod_seen !== 64'd63) begin n_fail++; $display("FAIL ignore_product got %0d want 63", prod_seen); end
    // request during the done cycle must also be dropped
    start = 1'b1; a_in = 64'd3; b_in = 64'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    idle_busy = 0;
    repeat (3) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0) idle_busy++;
    end
    n_checks++; if (idle_busy != 0) begin n_fail++; $display("FAIL ignore_done_start got %0d active cycles want 0", idle_busy); end
    n_checks++; if (product !== 64'd63) begin n_fail++; $display("FAIL ignore_hold got %0d want 63", product); end
    start_op(64'd2, 64'd2);
    collect(50);
    n_checks++; if (prod_seen !== 64'd4) begin n_fail++; $display("FAIL fresh_product got %0d want 4", prod_seen); end
    n_checks++; if (done_cycle != 6) begin n_fail++; $display("FAIL fresh_latency got %0d want 6", done_cycle); end
  endtask

  task automatic test_reset_mid();
    start_op(64'd6, 64'd3);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %b want 0", done); end
    n_checks++; if (product !== '0) begin n_fail++; $display("FAIL midreset_product got %h want 0", product); end
    n_checks++;
    if ({alu_A, alu_B, alu_FS, alu_C0} !== '0) begin
      n_fail++; $display("FAIL midreset_alu got A=%h B=%h FS=%b C0=%b want all 0", alu_A, alu_B, alu_FS, alu_C0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    start_op(64'd4, 64'd4);
    collect(50);
    n_checks++; if (prod_seen !== 64'd16) begin n_fail++; $display("FAIL postreset_product got %0d want 16", prod_seen); end
    n_checks++; if (done_cycle != 8) begin n_fail++; $display("FAIL postreset_latency got %0d want 8", done_cycle); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      r = {$urandom, $urandom};
      b = ($urandom_range(0, 7) == 0) ? '0 : (r >> $urandom_range(0, 63));
      start_op(a, b);
      collect(250);
      model_fs(b);
      n_checks++;
      if (prod_seen !== model_product(a, b)) begin
        n_fail++; $display("FAIL rand_product a=%h b=%h got %h want %h", a, b, prod_seen, model_product(a, b));
      end
      n_checks++;
      if (done_cycle != model_latency(b)) begin
        n_fail++; $display("FAIL rand_latency b=%h got %0d want %0d", b, done_cycle, model_latency(b));
      end
      n_checks++;
      if (fs_diff() != 0) begin
        n_fail++; $display("FAIL rand_fs_seq b=%h got %0d diffs want 0", b, fs_diff());
      end
    end
  endtask

  initial begin
    alu_status = 4'hA;
    test_reset();
    test_basic();
    test_zero();
    test_wrap();
    test_all_ones();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
